prog_update_ctrl: RTL and testbench
===================================

Name: prog_update_ctrl

Overview:
- Input conditioner that sits directly upstream of the programmable clock-divider block.
- Takes a raw "update" push-button and 3 raw rate-select slide switches.
- Synchronises and debounces them.
- Produces a registered 3-bit program value plus a single-cycle update strobe that the divider samples on its update/prog_in inputs.
- Guarantees exactly one update strobe per physical button press, regardless of contact bounce.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a press or a release (10 ms at 100 MHz); legal range 1 .. 2^CNT_W-1.
- CNT_W, 20, width of the debounce counter.
- PROG_W, 3, width of the program bus.

Ports:
- clock  input  1  system clock, 100 MHz.
- reset  input  1  reset; asynchronous assertion, active-low (0 = reset).
- btn_update  input  1  raw, asynchronous push-button; 1 = pressed.
- sw_prog  input  PROG_W  raw, asynchronous rate-select switches.
- update  output  1  one-cycle strobe; prog_out is valid in the same cycle.
- prog_out  output  PROG_W  committed program value, held between strobes.
- prog_pending  output  1  1 when synchronised switches differ from prog_out.
- btn_state  output  1  debounced button level, for an LED.

Behaviour:
- Synchronisers:
  - btn_update and sw_prog each pass through 2 flops → btn_s, sw_s.
  - All downstream logic uses only btn_s and sw_s.
  - Synchroniser flops reset to 0.
- Reset values (while reset=0): update=0, prog_out=0, btn_state=0, cnt=0, state=IDLE, prog_pending=0.
- FSM states: IDLE, DEB_PRESS, WAIT_RELEASE, DEB_RELEASE.
- IDLE:
  - btn_s=1 → DEB_PRESS, cnt<=0.
  - Otherwise stay in IDLE.
- DEB_PRESS:
  - btn_s=0 → IDLE, cnt<=0 (bounce rejected, no strobe).
  - btn_s=1 and cnt<DEBOUNCE_CYCLES-1 → cnt<=cnt+1.
  - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 → on this edge: prog_out<=sw_s, update<=1, btn_state<=1; next state WAIT_RELEASE.
- WAIT_RELEASE:
  - btn_s=0 → DEB_RELEASE, cnt<=0.
  - Otherwise stay in WAIT_RELEASE.
- DEB_RELEASE:
  - btn_s=1 → WAIT_RELEASE, cnt<=0.
  - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE, btn_state<=0.
  - Otherwise cnt<=cnt+1.
- update strobe:
  - Registered; high for exactly one cycle, the cycle after the accepting edge.
  - Cleared unconditionally on the following edge.
  - Never asserted in any state other than the transition out of DEB_PRESS.
- Timing and latency:
  - Acceptance needs btn_s=1 for DEBOUNCE_CYCLES+1 consecutive cycles (the IDLE detect cycle plus DEBOUNCE_CYCLES cycles in DEB_PRESS).
  - Raw-edge → update latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
- Switch capture:
  - Switches changing during debounce are allowed; the value captured is sw_s at the accepting edge.
  - Switch changes while no press is in progress affect only prog_pending, never prog_out.
- prog_pending = (sw_s != prog_out); combinational from registers.
- Press held indefinitely: the FSM stays in WAIT_RELEASE; no repeat strobe.
- Counter arithmetic: unsigned CNT_W; never wraps, because it is reset at every terminal count or state change.
- Reset mid-operation (any state): immediate return to reset values; a strobe in flight is cancelled; prog_out returns to 0, matching the divider's reset program.
- DEBOUNCE_CYCLES=1: a press is accepted when btn_s is high in the IDLE detect cycle and the following cycle.

Decomposition:
- Shared package prog_ctrl_pkg:
  - state typedef (IDLE, DEB_PRESS, WAIT_RELEASE, DEB_RELEASE, 2-bit encoding).
  - PROG_W=3.
  - DEBOUNCE_10MS=1_000_000.
  - SIM_DEBOUNCE=4 for benches.
- One sub-module: sync_2ff, a width-parameterised 2-flop synchroniser with async active-low reset to 0.
  - Instantiated once for btn_update (width 1) and once for sw_prog (width PROG_W).

Test Plan:
- Basic press (all scenarios use DEBOUNCE_CYCLES=4):
  - sw_prog=3'b101, btn_update raised cleanly at cycle 0 → update=1 for exactly one cycle at cycle 7, prog_out=3'b101 in that same cycle, btn_state=1.
  - Release: btn held 20 cycles then released → btn_state returns to 0 after 7 cycles; no further update.
- Bounce rejection: btn_update toggles 1,0,1,0,1 with 2-cycle pulses, then stays low → no update, prog_out unchanged, FSM back in IDLE.
- Switch change mid-debounce:
  - sw_prog=3'b001 at press, changed to 3'b110 two cycles before acceptance → prog_out=3'b110 at the strobe.
  - While idle, sw_prog=3'b011 with prog_out=3'b110 → prog_pending=1, prog_out unchanged.
- Release bounce: after acceptance, btn glitches low 2 cycles then high, repeated 3 times, then released → exactly one update total; btn_state drops only after 5 stable-low cycles following release sync.
- Reset mid-operation: reset driven 0 during DEB_PRESS at cnt=2, and separately in the cycle update=1 → update=0, prog_out=0, btn_state=0 immediately; the next clean press produces one normal strobe.

Source files
------------

// File: rtl/prog_ctrl_pkg.sv
// Shared types and constants for the divider program/update input conditioner.
package prog_ctrl_pkg;

    localparam int PROG_W        = 3;
    localparam int DEBOUNCE_10MS = 1_000_000;
    localparam int SIM_DEBOUNCE  = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        DEB_PRESS    = 2'b01,
        WAIT_RELEASE = 2'b10,
        DEB_RELEASE  = 2'b11
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterised two-flop synchroniser; both stages clear to 0 on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/prog_update_ctrl.sv
// Debounces the update button and commits the synchronised rate switches,
// emitting exactly one update strobe per accepted press.
module prog_update_ctrl #(
    parameter int DEBOUNCE_CYCLES = prog_ctrl_pkg::DEBOUNCE_10MS,
    parameter int CNT_W           = 20,
    parameter int PROG_W          = prog_ctrl_pkg::PROG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_update,
    input  logic [PROG_W-1:0] sw_prog,
    output logic              update,
    output logic [PROG_W-1:0] prog_out,
    output logic              prog_pending,
    output logic              btn_state
);

    import prog_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              btn_s;
    logic [PROG_W-1:0] sw_s;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              update_n;
    logic [PROG_W-1:0] prog_n;
    logic              btn_state_n;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync_btn (
        .clock  (clock),
        .reset  (reset),
        .raw    (btn_update),
        .synced (btn_s)
    );

    sync_2ff #(
        .WIDTH (PROG_W)
    ) u_sync_sw (
        .clock  (clock),
        .reset  (reset),
        .raw    (sw_prog),
        .synced (sw_s)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            update    <= 1'b0;
            prog_out  <= '0;
            btn_state <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            update    <= update_n;
            prog_out  <= prog_n;
            btn_state <= btn_state_n;
        end
    end

    // The counter is cleared on every state change and at terminal count,
    // so it can never wrap.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        update_n    = 1'b0;
        prog_n      = prog_out;
        btn_state_n = btn_state;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_n = DEB_PRESS;
                    cnt_n   = '0;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n     = WAIT_RELEASE;
                    cnt_n       = '0;
                    update_n    = 1'b1;
                    prog_n      = sw_s;
                    btn_state_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT_RELEASE: begin
                if (!btn_s) begin
                    state_n = DEB_RELEASE;
                    cnt_n   = '0;
                end
            end
            DEB_RELEASE: begin
                if (btn_s) begin
                    state_n = WAIT_RELEASE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n     = IDLE;
                    cnt_n       = '0;
                    btn_state_n = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign prog_pending = (sw_s != prog_out);

endmodule

// File: tb/tb_prog_update_ctrl.sv
// Bench for prog_update_ctrl: directed scenarios plus randomized button/switch
// activity, checked against a run-length debounce reference model.
module tb_prog_update_ctrl;

    import prog_ctrl_pkg::*;

    localparam int D = SIM_DEBOUNCE;

    logic       clock;
    logic       reset;
    logic       btn_update;
    logic [2:0] sw_prog;
    logic       update;
    logic [2:0] prog_out;
    logic       prog_pending;
    logic       btn_state;

    int unsigned checks = 0;
    int unsigned errors = 0;

    prog_update_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (20),
        .PROG_W          (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_update   (btn_update),
        .sw_prog      (sw_prog),
        .update       (update),
        .prog_out     (prog_out),
        .prog_pending (prog_pending),
        .btn_state    (btn_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: debounced level flips after D+1 consecutive synchronised
    // samples that disagree with it; a flip to 1 commits the switches.
    logic        m_b1, m_b2, m_level, m_update;
    logic [2:0]  m_sw1, m_sw2, m_prog;
    int unsigned m_run;
    logic        m_pend;

    assign m_pend = (m_sw2 != m_prog);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_b1 <= 1'b0; m_b2 <= 1'b0; m_sw1 <= '0; m_sw2 <= '0;
            m_level <= 1'b0; m_run <= 0; m_update <= 1'b0; m_prog <= '0;
        end else begin
            int unsigned run_len;
            run_len = (m_b2 != m_level) ? m_run + 1 : 0;
            m_update <= 1'b0;
            if (run_len == D + 1) begin
                m_level <= m_b2;
                run_len = 0;
                if (m_b2) begin
                    m_update <= 1'b1;
                    m_prog   <= m_sw2;
                end
            end
            m_run <= run_len;
            m_b1  <= btn_update;
            m_b2  <= m_b1;
            m_sw1 <= sw_prog;
            m_sw2 <= m_sw1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        reset = 1'b0; btn_update = 1'b1; sw_prog = 3'b111;
        repeat (3) @(negedge clock);
        checks++;
        if ({update, prog_out, btn_state, prog_pending} !== 6'b0) begin
            errors++;
            $display("FAIL reset_values got %b exp %b", {update, prog_out, btn_state, prog_pending}, 6'b0);
        end
        btn_update = 1'b0; sw_prog = 3'b000; reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            checks++;
            if ({update, prog_out, btn_state, prog_pending} !== {m_update, m_prog, m_level, m_pend}) begin
                errors++;
                $display("FAIL reset_model got %b exp %b", {update, prog_out, btn_state, prog_pending}, {m_update, m_prog, m_level, m_pend});
            end
        end
    endtask

    task automatic test_basic_press;
        int first = 0;
        int ups = 0;
        int rel = 0;
        sw_prog = 3'b101;
        repeat (6) @(negedge clock);
        btn_update = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            checks++;
            if ({update, prog_out, btn_state, prog_pending} !== {m_update, m_prog, m_level, m_pend}) begin
                errors++;
                $display("FAIL basic_model c=%0d got %b exp %b", c, {update, prog_out, btn_state, prog_pending}, {m_update, m_prog, m_level, m_pend});
            end
            if (update) begin
                ups++;
                if (first == 0) begin
                    first = c;
                    checks++;
                    if ({prog_out, btn_state} !== 4'b1011) begin
                        errors++;
                        $display("FAIL basic_strobe_value got %b exp %b", {prog_out, btn_state}, 4'b1011);
                    end
                end
            end
        end
        checks++;
        if (first != 7 || ups != 1) begin
            errors++;
            $display("FAIL basic_latency got cycle %0d count %0d exp cycle 7 count 1", first, ups);
        end
        btn_update = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            checks++;
            if ({update, prog_out, btn_state, prog_pending} !== {m_update, m_prog, m_level, m_pend}) begin
                errors++;
                $display("FAIL release_model c=%0d got %b exp %b", c, {update, prog_out, btn_state, prog_pending}, {m_update, m_prog, m_level, m_pend});
            end
            if (update) ups++;
            if (rel == 0 && !btn_state) rel = c;
        end
        checks++;
        if (rel != 7 || ups != 1) begin
            errors++;
            $display("FAIL release_latency got cycle %0d count %0d exp cycle 7 count 1", rel, ups);
        end
    endtask

    task automatic test_bounce;
        int ups = 0;
        logic [4:0] pat;
        pat = 5'b10101;
        sw_prog = 3'b010;
        for (int p = 4; p >= 0; p--) begin
            btn_update = pat[p];
            repeat (2) begin
                @(negedge clock);
                checks++;
                if ({update, prog_out, btn_state, prog_pending} !== {m_update, m_prog, m_level, m_pend}) begin
                    errors++;
                    $display("FAIL bounce_model got %b exp %b", {update, prog_out, btn_state, prog_pending}, {m_update, m_prog, m_level, m_pend});
                end
                if (update) ups++;
            end
        end
        btn_update = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (update) ups++;
        end
        checks++;
        if (ups != 0 || prog_out !== 3'b101 || btn_state !== 1'b0 || prog_pending !== 1'b1) begin
            errors++;
            $display("FAIL bounce_reject got ups %0d prog %b btn %b pend %b exp 0 101 0 1", ups, prog_out, btn_state, prog_pending);
        end
    endtask

    task automatic test_switch_mid;
        int first = 0;
        sw_prog = 3'b001;
        btn_update = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            checks++;
            if ({update, prog_out, btn_state, prog_pending} !== {m_update, m_prog, m_level, m_pend}) begin
                errors++;
                $display("FAIL switch_model c=%0d got %b exp %b", c, {update, prog_out, btn_state, prog_pending}, {m_update, m_prog, m_level, m_pend});
            end
            if (update && first == 0) first = c;
            if (c == 4) sw_prog = 3'b110;
        end
        checks++;
        if (first != 7 || prog_out !== 3'b110) begin
            errors++;
            $display("FAIL switch_capture got cycle %0d prog %b exp cycle 7 prog 110", first, prog_out);
        end
        btn_update = 1'b0;
        repeat (12) @(negedge clock);
        sw_prog = 3'b011;
        repeat (3) @(negedge clock);
        checks++;
        if (prog_pending !== 1'b1 || prog_out !== 3'b110) begin
            errors++;
            $display("FAIL switch_idle_pending got pend %b prog %b exp 1 110", prog_pending, prog_out);
        end
    endtask

    task automatic test_release_bounce;
        int ups = 0;
        int rel = 0;
        sw_prog = 3'b111;
        btn_update = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (update) ups++;
        end
        repeat (3) begin
            btn_update = 1'b0;
            repeat (2) begin
                @(negedge clock);
                checks++;
                if ({update, prog_out, btn_state, prog_pending} !== {m_update, m_prog, m_level, m_pend}) begin
                    errors++;
                    $display("FAIL relbounce_model got %b exp %b", {update, prog_out, btn_state, prog_pending}, {m_update, m_prog, m_level, m_pend});
                end
                if (update) ups++;
            end
            btn_update = 1'b1;
            repeat (4) begin
                @(negedge clock);
                if (update) ups++;
            end
        end
        btn_update = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (update) ups++;
            if (rel == 0 && !btn_state) rel = c;
        end
        checks++;
        if (ups != 1 || rel != 7 || prog_out !== 3'b111) begin
            errors++;
            $display("FAIL relbounce_result got ups %0d rel %0d prog %b exp 1 7 111", ups, rel, prog_out);
        end
    endtask

    task automatic test_reset_mid;
        int first = 0;
        int ups = 0;
        sw_prog = 3'b010;
        btn_update = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({update, prog_out, btn_state} !== 5'b0) begin
            errors++;
            $display("FAIL reset_in_press got %b exp %b", {update, prog_out, btn_state}, 5'b0);
        end
        btn_update = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        btn_update = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            if (update) begin ups++; if (first == 0) first = c; end
        end
        checks++;
        if (first != 7 || ups != 1 || update !== 1'b1 || prog_out !== 3'b010) begin
            errors++;
            $display("FAIL reset_repress got cycle %0d ups %0d upd %b prog %b exp 7 1 1 010", first, ups, update, prog_out);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({update, prog_out, btn_state} !== 5'b0) begin
            errors++;
            $display("FAIL reset_in_strobe got %b exp %b", {update, prog_out, btn_state}, 5'b0);
        end
        btn_update = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        first = 0; ups = 0;
        sw_prog = 3'b100;
        btn_update = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            checks++;
            if ({update, prog_out, btn_state, prog_pending} !== {m_update, m_prog, m_level, m_pend}) begin
                errors++;
                $display("FAIL postreset_model c=%0d got %b exp %b", c, {update, prog_out, btn_state, prog_pending}, {m_update, m_prog, m_level, m_pend});
            end
            if (update) begin ups++; if (first == 0) first = c; end
        end
        checks++;
        if (first != 7 || ups != 1 || prog_out !== 3'b100) begin
            errors++;
            $display("FAIL postreset_press got cycle %0d ups %0d prog %b exp 7 1 100", first, ups, prog_out);
        end
        btn_update = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_back_to_back;
        int ups = 0;
        logic [2:0] last;
        last = 3'b000;
        // D high samples is one short of acceptance
        btn_update = 1'b1;
        repeat (D) @(negedge clock);
        btn_update = 1'b0;
        repeat (D + 1) begin
            @(negedge clock);
            if (update) ups++;
        end
        repeat (4) @(negedge clock);
        checks++;
        if (ups != 0 || btn_state !== 1'b0) begin
            errors++;
            $display("FAIL short_press got ups %0d btn %b exp 0 0", ups, btn_state);
        end
        for (int k = 0; k < 4; k++) begin
            sw_prog = 3'($urandom_range(0, 7));
            last = sw_prog;
            btn_update = 1'b1;
            repeat (D + 1) begin
                @(negedge clock);
                if (update) ups++;
            end
            btn_update = 1'b0;
            repeat (D + 1) begin
                @(negedge clock);
                if (update) ups++;
                checks++;
                if ({update, prog_out, btn_state, prog_pending} !== {m_update, m_prog, m_level, m_pend}) begin
                    errors++;
                    $display("FAIL b2b_model k=%0d got %b exp %b", k, {update, prog_out, btn_state, prog_pending}, {m_update, m_prog, m_level, m_pend});
                end
            end
        end
        repeat (4) @(negedge clock);
        checks++;
        if (ups != 4 || prog_out !== last) begin
            errors++;
            $display("FAIL b2b_count got ups %0d prog %b exp 4 %b", ups, prog_out, last);
        end
    endtask

    task automatic test_random;
        int hold = 0;
        int m_ups = 0;
        int d_ups = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                btn_update = ~btn_update;
                hold = $urandom_range(1, 9);
                if ($urandom_range(0, 5) == 0) hold = 40;
            end
            hold--;
            if ($urandom_range(0, 7) == 0) sw_prog = 3'($urandom_range(0, 7));
            @(negedge clock);
            if (update) d_ups++;
            if (m_update) m_ups++;
            checks++;
            if ({update, prog_out, btn_state, prog_pending} !== {m_update, m_prog, m_level, m_pend}) begin
                errors++;
                $display("FAIL random_model c=%0d got %b exp %b", c, {update, prog_out, btn_state, prog_pending}, {m_update, m_prog, m_level, m_pend});
            end
        end
        btn_update = 1'b0;
        repeat (12) @(negedge clock);
        checks++;
        if (d_ups != m_ups || m_ups == 0) begin
            errors++;
            $display("FAIL random_strobes got %0d exp %0d (nonzero)", d_ups, m_ups);
        end
    endtask

    initial begin
        reset = 1'b0;
        btn_update = 1'b0;
        sw_prog = 3'b000;
        test_reset();
        test_basic_press();
        test_bounce();
        test_switch_mid();
        test_release_bounce();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
